imem_arbiter: RTL and testbench

- Shares the single-port, byte-addressed, little-endian instruction memory between the core's instruction-fetch port and the program loader/debug port.
- Arbitrates requests round-robin.
- Holds one transaction outstanding at a time.
- Checks alignment and range, and returns one response per accepted request.
- Sits between the fetch stage/loader and a synchronous-read memory macro. Read data is valid the cycle after enable.

---
 rtl/imem_arbiter.sv | 82 ++++++++
 tb/tb_imem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of a single-port synchronous-read instruction memory
// between the fetch port and the loader/debug port, one transaction outstanding at a time.
module imem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int MA_W = $clog2(MEM_BYTES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_req_valid,
  output logic            f_req_ready,
  input  logic [31:0]     f_addr,
  output logic            f_resp_valid,
  output logic [31:0]     f_rdata,
  output logic            f_err,
  input  logic            l_req_valid,
  output logic            l_req_ready,
  input  logic            l_we,
  input  logic [31:0]     l_addr,
  input  logic [31:0]     l_wdata,
  input  logic [3:0]      l_be,
  input  logic            l_hold,
  output logic            l_resp_valid,
  output logic [31:0]     l_rdata,
  output logic            l_err,
  output logic            m_en,
  output logic            m_we,
  output logic [MA_W-1:0] m_addr,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_be,
  input  logic [31:0]     m_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t state_q, state_d;
  logic last_q;
  logic we_q, f_resp_valid_q, l_resp_valid_q, f_err_q, l_err_q;
  logic f_elig, f_win, l_win, idle, accept, bad;
  logic [31:0] addr;
  // last_q=1 means the loader was granted last, so fetch wins the next tie
  always_comb begin
    f_elig = f_req_valid & ~l_hold;
    f_win = f_elig & (~l_req_valid | last_q);
    l_win = l_req_valid & (~f_elig | ~last_q);
    idle = ~rst & (state_q == IDLE);
    f_req_ready = idle & f_win;
    l_req_ready = idle & l_win;
    accept = f_req_ready | l_req_ready;
    addr = l_win ? l_addr : f_addr;
    bad = (addr[1:0] != 2'b00) | (addr > 32'(MEM_BYTES - 4));
    m_en = accept & ~bad;
    m_we = m_en & l_win & l_we;
    m_addr = addr[MA_W-1:0];
    m_wdata = l_win ? l_wdata : 32'h0;
    m_be = l_win ? l_be : 4'hf;
    state_d = accept ? (bad ? ERR : BUSY) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      we_q <= 1'b0;
      f_resp_valid_q <= 1'b0;
      l_resp_valid_q <= 1'b0;
      f_err_q <= 1'b0;
      l_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      f_resp_valid_q <= f_req_ready;
      l_resp_valid_q <= l_req_ready;
      f_err_q <= f_req_ready & bad;
      l_err_q <= l_req_ready & bad;
      we_q <= m_we;
      if (accept) last_q <= l_win;
    end
  end
  // read data comes straight from the macro during the response cycle; writes return zero
  assign f_resp_valid = f_resp_valid_q;
  assign l_resp_valid = l_resp_valid_q;
  assign f_err = f_err_q;
  assign l_err = l_err_q;
  assign f_rdata = (state_q == BUSY && f_resp_valid_q) ? m_rdata : 32'h0;
  assign l_rdata = (state_q == BUSY && l_resp_valid_q && !we_q) ? m_rdata : 32'h0;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized and directed stimulus against a byte-level reference model,
// with expected responses queued per port and checked by an independent monitor.
module tb_imem_arbiter;
  localparam int MEM_BYTES = 1024;
  localparam int MA_W = $clog2(MEM_BYTES);
  typedef struct packed {logic [31:0] cyc; logic err; logic [31:0] rdata;} resp_t;
  logic clk = 0, rst = 1, load = 1;
  logic f_req_valid = 0, f_req_ready, f_resp_valid, f_err;
  logic [31:0] f_addr = 0, f_rdata;
  logic l_req_valid = 0, l_req_ready, l_we = 0, l_hold = 0, l_resp_valid, l_err;
  logic [31:0] l_addr = 0, l_wdata = 0, l_rdata;
  logic [3:0] l_be = 0;
  logic m_en, m_we;
  logic [MA_W-1:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0] m_be;
  logic [31:0] mem [MEM_BYTES/4];
  logic [7:0] rmem [MEM_BYTES];
  logic [31:0] cyc = 0;
  resp_t q [2][$];
  int n_cmp = 0, n_bad = 0;
  bit idle_m = 1, last_m = 1;
  imem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
    .f_resp_valid(f_resp_valid), .f_rdata(f_rdata), .f_err(f_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_we(l_we), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_be(l_be), .l_hold(l_hold),
    .l_resp_valid(l_resp_valid), .l_rdata(l_rdata), .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // memory macro: synchronous read, byte-enabled write, preloaded from the reference image
  always @(posedge clk) begin
    if (load)
      for (int w = 0; w < MEM_BYTES/4; w++)
        mem[w] <= {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
    else if (m_en) begin
      for (int i = 0; i < 4; i++)
        if (m_we && m_be[i]) mem[m_addr[MA_W-1:2]][8*i+:8] <= m_wdata[8*i+:8];
      m_rdata <= mem[m_addr[MA_W-1:2]];
    end
  end
  a_f_stable: assert property (@(posedge clk) disable iff (rst)
    f_req_valid && !f_req_ready |=> f_req_valid && $stable(f_addr));
  a_l_stable: assert property (@(posedge clk) disable iff (rst)
    l_req_valid && !l_req_ready |=> l_req_valid && $stable({l_we, l_addr, l_wdata, l_be}));
  task automatic check(string nm, logic [79:0] act, logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic chk(int p, logic v, logic e, logic [31:0] d);
    resp_t x;
    if (v) begin
      if (q[p].size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL resp%0d unexpected at cycle %0d: err=%b rdata=%h", p, cyc, e, d);
      end else begin
        x = q[p].pop_front();
        check($sformatf("resp%0d {cyc,err,rdata}", p), 80'({cyc, e, d}), 80'(x));
      end
    end else begin
      check($sformatf("idle%0d {err,rdata}", p), 80'({e, d}), 80'(0));
      if (q[p].size() != 0 && q[p][0].cyc <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL resp%0d missing at cycle %0d: got none expected cycle %0d", p, cyc, q[p][0].cyc);
        void'(q[p].pop_front());
      end
    end
  endtask
  always @(negedge clk) begin
    chk(0, f_resp_valid, f_err, f_rdata);
    chk(1, l_resp_valid, l_err, l_rdata);
  end
  function automatic logic [31:0] rd(logic [31:0] a);
    return {rmem[a+3], rmem[a+2], rmem[a+1], rmem[a]};
  endfunction
  // one clock of the reference model; called at posedge+1 with inputs already applied
  task automatic tick();
    bit fe, fw, lw, acc, bad;
    logic [31:0] a, ed;
    fe = f_req_valid && !l_hold;
    fw = !rst && idle_m && fe && (!l_req_valid || last_m);
    lw = !rst && idle_m && l_req_valid && (!fe || !last_m);
    acc = fw || lw;
    a = lw ? l_addr : f_addr;
    bad = (a % 4 != 0) || (a > 32'(MEM_BYTES - 4));
    #2;
    check("ready {f,l}", 80'({f_req_ready, l_req_ready}), 80'({fw, lw}));
    if (acc && !bad)
      check("mem bus {en,we,be,addr,wdata}", 80'({m_en, m_we, m_be, m_addr, m_wdata}),
            80'({1'b1, lw && l_we, lw ? l_be : 4'hf, a[MA_W-1:0], lw ? l_wdata : 32'h0}));
    else
      check("m_en", 80'(m_en), 80'(0));
    if (acc) begin
      ed = 0;
      if (!bad) begin
        if (lw && l_we) begin
          for (int i = 0; i < 4; i++) if (l_be[i]) rmem[a + i] = l_wdata[8*i+:8];
        end else ed = rd(a);
      end
      q[int'(lw)].push_back({cyc + 32'd1, bad, ed});
      last_m = lw;
    end
    @(posedge clk); #1;
    if (rst) begin
      idle_m = 1; last_m = 1;
    end else begin
      idle_m = !acc;
      if (fw) f_req_valid = 0;
      if (lw) l_req_valid = 0;
    end
  endtask
  task automatic post_f(logic [31:0] a);
    if (!f_req_valid) begin f_req_valid = 1; f_addr = a; end
  endtask
  task automatic post_l(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
    if (!l_req_valid) begin l_req_valid = 1; l_we = we; l_addr = a; l_wdata = wd; l_be = be; end
  endtask
  task automatic drain();
    int n = 0;
    l_hold = 0;
    while ((f_req_valid || l_req_valid || !idle_m) && n < 20) begin tick(); n++; end
    if (n == 20) begin n_cmp++; n_bad++; $display("FAIL drain: got pending requests expected none"); end
    tick();
  endtask
  task automatic reset_dut(int n);
    rst = 1;
    q[0].delete(); q[1].delete();
    repeat (n) tick();
    rst = 0;
  endtask
  function automatic logic [31:0] raddr();
    case ($urandom_range(7))
      0: return $urandom;
      1: return 32'($urandom_range(MEM_BYTES - 1));
      2: return 32'(MEM_BYTES - 4 + 4 * $urandom_range(1));
      default: return 32'($urandom_range(MEM_BYTES/4 - 1)) << 2;
    endcase
  endfunction
  initial begin
    logic [31:0] v;
    for (int w = 0; w < MEM_BYTES/4; w++) begin
      v = (w == 4) ? 32'h00000013 : $urandom;
      for (int i = 0; i < 4; i++) rmem[4*w+i] = v[8*i+:8];
    end
    @(posedge clk); #1;
    f_req_valid = 1; l_req_valid = 1;
    reset_dut(3);
    f_req_valid = 0; l_req_valid = 0;
    load = 0;
    // both requesters saturated from reset: grants alternate starting with fetch
    for (int k = 0; k < 8; k++) begin post_f(0); post_l(0, 4, 0, 0); tick(); end
    drain();
    post_f(32'h10); tick(); tick();
    // hold blocks fetch while the loader writes two bytes
    l_hold = 1; post_f(32'h30); post_l(1, 32'h20, 32'hDEADBEEF, 4'b0011);
    repeat (3) tick();
    post_l(0, 32'h20, 0, 0); repeat (3) tick();
    drain();
    post_f(32'h102); tick(); tick();
    post_l(0, 32'h3FD, 0, 0); tick(); tick();
    post_l(0, 32'h3FC, 0, 0); tick(); tick();
    post_l(1, 32'h3FC, $urandom, 4'b0000); tick(); tick();
    post_l(0, 32'h3FC, 0, 0); tick(); tick();
    // reset in the response cycle drops that response; fetch then wins the first tie
    post_f(32'h40); post_l(0, 32'h44, 0, 0); tick();
    reset_dut(2);
    post_f(32'h40); post_l(0, 32'h44, 0, 0); repeat (4) tick();
    drain();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(2) == 0) post_f(raddr());
      if ($urandom_range(2) == 0) post_l(1'($urandom), raddr(), $urandom, 4'($urandom));
      l_hold = ($urandom_range(4) == 0);
      tick();
    end
    drain();
    check("leftover expected responses", 80'(q[0].size() + q[1].size()), 80'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
